// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//   Programmable-modulus up-counter. The count runs 0..data (data inclusive),
//   advancing by STEP on each enabled cycle. It then wraps to 0, and a
//   registered terminal-count pulse is raised for one cycle on the wrap.
//   Use it as a general timebase or clock-enable divider.
//
// Parameters
//   WIDTH : bit width of data and out
//   STEP  : increment per enabled cycle (1 .. 2**WIDTH-1)
//
// Ports
//   clk  : clock, all state updates on posedge
//   rstb : synchronous reset, active-high; overrides en and data
//   en   : count enable, active-high
//   data : terminal value, inclusive upper bound; sampled live each cycle
//   out  : current count, registered
//   tc   : terminal-count pulse, registered, high for one cycle on wrap
// -----------------------------------------------------------------------------
module mod_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] out,
    output logic             tc
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   data_ext;

    // The sum carries one extra bit, so a step past 2**WIDTH-1 cannot alias
    // back into range and look like a valid count.
    assign sum_ext  = {1'b0, out_q} + STEP_EXT;
    assign data_ext = {1'b0, data};

    always_comb begin
        out_d = out_q;
        tc_d  = 1'b0;
        if (en) begin
            // STEP >= 1, so sum <= data already implies out < data.
            // The out >= data case (data lowered mid-count, or data = 0)
            // therefore takes the wrap branch.
            if (sum_ext <= data_ext) begin
                out_d = sum_ext[WIDTH-1:0];
            end else begin
                out_d = '0;
                tc_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            out_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
        end
    end

    assign out = out_q;
    assign tc  = tc_q;

endmodule

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

    typedef struct {
        logic [7:0] exp_out;
        logic       exp_tc;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rstb;
    logic       en;
    logic [7:0] data;
    logic [7:0] out;
    logic       tc;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    mod_counter #(.WIDTH(8), .STEP(1)) dut (
        .clk  (clk),
        .rstb (rstb),
        .en   (en),
        .data (data),
        .out  (out),
        .tc   (tc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The DUT presents a registered result after every posedge. At the
    // following negedge, pop the expectation that was queued for that edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks = checks + 1;
            if (out !== e.exp_out || tc !== e.exp_tc) begin
                failures = failures + 1;
                $display("FAIL %s: out=%0d tc=%0b, expected out=%0d tc=%0b",
                         e.tag, out, tc, e.exp_out, e.exp_tc);
            end
        end
    end

    // Drive one cycle of inputs and queue the hand-computed result for the
    // edge that samples them.
    task automatic step(input logic r, input logic e, input logic [7:0] d,
                        input logic [7:0] xo, input logic xt, input string tag);
        exp_t x;
        rstb = r;
        en   = e;
        data = d;
        x.exp_out = xo;
        x.exp_tc  = xt;
        x.tag     = tag;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstb = 1'b1;
        en   = 1'b1;
        data = 8'd255;

        // 1: reset held for 3 cycles with en=1
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'd255, 8'd0, 1'b0, "reset_hold");

        // 2: full binary count, 300 cycles; tc only on 255->0
        for (int k = 1; k <= 300; k++)
            step(1'b0, 1'b1, 8'd255, 8'(k % 256), (k % 256) == 0, "full_count");

        // 3: data=4 -> 1,2,3,4,0(tc),1
        step(1'b1, 1'b1, 8'd4, 8'd0, 1'b0, "reset_mid");
        step(1'b0, 1'b1, 8'd4, 8'd1, 1'b0, "mod5");
        step(1'b0, 1'b1, 8'd4, 8'd2, 1'b0, "mod5");
        step(1'b0, 1'b1, 8'd4, 8'd3, 1'b0, "mod5");
        step(1'b0, 1'b1, 8'd4, 8'd4, 1'b0, "mod5");
        step(1'b0, 1'b1, 8'd4, 8'd0, 1'b1, "mod5_wrap");
        step(1'b0, 1'b1, 8'd4, 8'd1, 1'b0, "mod5_after");
        // hold right after a wrap: tc must drop
        step(1'b0, 1'b1, 8'd4, 8'd2, 1'b0, "mod5");
        step(1'b0, 1'b1, 8'd4, 8'd3, 1'b0, "mod5");
        step(1'b0, 1'b1, 8'd4, 8'd4, 1'b0, "mod5");
        step(1'b0, 1'b1, 8'd4, 8'd0, 1'b1, "mod5_wrap2");
        step(1'b0, 1'b0, 8'd4, 8'd0, 1'b0, "hold_after_wrap");

        // 4: data=9, count to 5, hold 4 cycles, resume to 6
        step(1'b1, 1'b0, 8'd9, 8'd0, 1'b0, "reset_mid");
        for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, 8'd9, 8'(k), 1'b0, "to5");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd9, 8'd5, 1'b0, "hold5");
        step(1'b0, 1'b1, 8'd9, 8'd6, 1'b0, "resume6");

        // 5: count to 7, then lower data to 3 -> wrap on next enabled edge
        step(1'b0, 1'b1, 8'd9, 8'd7, 1'b0, "to7");
        step(1'b0, 1'b0, 8'd3, 8'd7, 1'b0, "lower_data_hold");
        step(1'b0, 1'b1, 8'd3, 8'd0, 1'b1, "lower_data_wrap");
        step(1'b0, 1'b1, 8'd3, 8'd1, 1'b0, "after_lower");

        // data=0: stays 0, tc every enabled cycle, none when disabled
        step(1'b0, 1'b1, 8'd0, 8'd0, 1'b1, "data0");
        step(1'b0, 1'b1, 8'd0, 8'd0, 1'b1, "data0");
        step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, "data0_dis");
        step(1'b0, 1'b1, 8'd0, 8'd0, 1'b1, "data0");

        // 6: count to 100, 1-cycle reset with en=1, then 1,2
        step(1'b1, 1'b1, 8'd255, 8'd0, 1'b0, "reset_mid");
        for (int k = 1; k <= 100; k++) step(1'b0, 1'b1, 8'd255, 8'(k), 1'b0, "to100");
        step(1'b1, 1'b1, 8'd255, 8'd0, 1'b0, "reset_over_en");
        step(1'b0, 1'b1, 8'd255, 8'd1, 1'b0, "post_reset");
        step(1'b0, 1'b1, 8'd255, 8'd2, 1'b0, "post_reset");

        // reset with data=X must still clear cleanly
        step(1'b1, 1'b1, 8'bx, 8'd0, 1'b0, "reset_data_x");
        step(1'b0, 1'b1, 8'd255, 8'd1, 1'b0, "after_x_reset");

        @(negedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain: pending=%0d, expected pending=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
